pipe_stall_ctrl: RTL

Central stall/flush sequencer for the five-stage MIPS pipeline. It drives the PC enable, the IF/ID register enable and flush, and the ID/EX bubble insertion. It also runs the multiply/divide busy counter and sequences exception entry and eret redirection. It sits beside the hazard detector and CP0 in the top-level CPU.

---
 rtl/pipe_stall_ctrl.sv | 99 +++++++++
 1 files changed

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: PC/IF-ID enables, bubbles,
// mult/div busy tracking, and exception-entry / eret redirection sequencing.
module pipe_stall_ctrl #(
    parameter int unsigned MULT_LAT = 5,
    parameter int unsigned DIV_LAT  = 10,
    parameter int unsigned CNT_W    = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic stall_hazard,
    input  logic md_start,
    input  logic md_is_div,
    input  logic md_use_D,
    input  logic eret_D,
    input  logic exc_req,
    output logic pc_en,
    output logic if_id_en,
    output logic if_id_clr,
    output logic id_ex_clr,
    output logic flush_all,
    output logic md_busy
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        EXC_DRAIN  = 2'd1,
        ERET_FLUSH = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] md_cnt_q, md_cnt_d;

    logic exc_eff;
    logic md_start_eff;
    logic stall;

    // A mult/div in E is younger than the excepting M instruction, so it is cancelled.
    assign exc_eff      = exc_req & (state_q != EXC_DRAIN);
    assign md_start_eff = md_start & ~exc_eff;
    assign md_busy      = md_start_eff | (md_cnt_q != '0);
    assign stall        = stall_hazard | (md_use_D & md_busy);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= RUN;
            md_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
        end
    end

    // Busy counter: a new issue reloads; an exception lets an older op finish.
    always_comb begin
        md_cnt_d = md_cnt_q;
        if (md_start_eff) begin
            md_cnt_d = md_is_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
        end else if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - CNT_W'(1);
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_en     = 1'b1;
        if_id_en  = 1'b1;
        if_id_clr = 1'b0;
        id_ex_clr = 1'b0;
        flush_all = 1'b0;

        if (exc_eff) begin
            flush_all = 1'b1;
            if_id_clr = 1'b1;
            id_ex_clr = 1'b1;
            if_id_en  = 1'b0;
        end else if (state_q == ERET_FLUSH) begin
            if_id_clr = 1'b1;
            if_id_en  = 1'b0;
            id_ex_clr = stall;
        end else if (stall) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_clr = 1'b1;
        end

        // A stalled eret waits in RUN; the flush cycle squashes eret+4.
        if (exc_eff) begin
            state_d = EXC_DRAIN;
        end else begin
            case (state_q)
                RUN:        if (eret_D && !stall) state_d = ERET_FLUSH;
                EXC_DRAIN:  state_d = RUN;
                ERET_FLUSH: state_d = RUN;
                default:    state_d = RUN;
            endcase
        end
    end

endmodule
